rs_array: RTL
=============

# rs_array

Parametrised multi-entry reservation station that succeeds the single-entry `reservation_station`. It sits between dispatch and one functional unit (`stage_ex`) and holds up to `NUM_ENTRIES` in-flight instructions. Each entry snoops the CDB for missing operands. The block issues the oldest entry whose operands are ready whenever the FU accepts.

## Interface

Parameters
- `NUM_ENTRIES`, default 4: number of station entries, ≥2.
- `XLEN`, default 32: operand and data width.
- `TAG_BITS`, default `ROB_TAG_BITS`: ROB tag width.
- `FUNC_BITS`, default 5: width of the `ALU_FUNC` encoding.

Ports
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries (mispredict recovery).
- `alloc_valid` in 1: dispatch presents an instruction.
- `alloc_ready` out 1: at least one free entry exists.
- `alloc_opa`, `alloc_opb` in XLEN: operand values.
- `alloc_opa_valid`, `alloc_opb_valid` in 1: the corresponding operand value is already valid.
- `alloc_opa_tag`, `alloc_opb_tag` in TAG_BITS: producer ROB tag when the operand is not valid.
- `alloc_rob_tag` in TAG_BITS: destination ROB tag.
- `alloc_func` in FUNC_BITS: ALU function.
- `alloc_npc` in XLEN: next PC.
- `alloc_rd_mem`, `alloc_wr_mem` in 1: memory-op flags.
- `cdb_valid` in 1, `cdb_tag` in TAG_BITS, `cdb_data` in XLEN: common data bus broadcast.
- `issue_valid` out 1: an entry is ready to issue.
- `issue_ready` in 1: FU can accept (the inverse of `fu_busy`).
- `issue_opa`, `issue_opb` out XLEN; `issue_rob_tag` out TAG_BITS; `issue_func` out FUNC_BITS; `issue_npc` out XLEN; `issue_rd_mem`, `issue_wr_mem` out 1: fields of the issuing entry.
- `free_count` out $clog2(NUM_ENTRIES+1): number of free entries.

## Operation

Entry contents: busy, opa/opb value, opa/opb valid, opa/opb tag, rob_tag, func, npc, rd_mem, wr_mem.

Ordering: an N×N age matrix tracks program order. Bit [i][j]=1 means entry i is older than entry j.

Allocation
- Allocation occurs when `alloc_valid && alloc_ready`. The instruction is written to the lowest-index free entry.
- On allocation, the new entry is marked younger than every busy entry.
- `alloc_valid` while `!alloc_ready` is ignored; no state changes.

Allocation bypass
- If an incoming operand is not valid but `cdb_valid` is set and `cdb_tag` equals that operand's tag in the same cycle, the entry stores `cdb_data` and sets the operand valid.

Wakeup
- Every busy entry compares each invalid operand tag against `cdb_tag` when `cdb_valid` is set. On a match it latches `cdb_data` and sets valid.
- Both operands may wake in the same cycle, and multiple entries may wake on one broadcast.

Select
- An entry is ready when it is busy and both operands are valid.
- Among ready entries, the one older than all other ready entries is selected. `issue_*` carries its fields.
- `issue_*` outputs are driven purely from registered state; there is no combinational CDB→issue path.
- When `issue_valid` is 0, the data outputs are don't-care; the bench must not check them.

Issue
- Issue fires when `issue_valid && issue_ready`. The selected entry's busy bit clears at that edge.
- When `issue_ready` is 0, `issue_valid` and the `issue_*` fields are held stable.

Same-cycle issue and allocation
- A slot freed by issue is not visible to `alloc_ready` until the next cycle.
- `alloc_ready` is computed from registered busy bits only.

Flush and reset
- `flush` clears all busy bits at the edge and takes priority over a simultaneous allocation.
- `reset` behaves the same as `flush` and also clears the age matrix.

## Timing

Reset values:
- `alloc_ready`=1, `free_count`=NUM_ENTRIES.
- `issue_valid`=0, all `issue_*` data outputs = 0.

Latencies:
- Allocation with both operands valid at edge t: `issue_valid`=1 during cycle t+1.
- CDB match captured at edge t: the entry becomes selectable in cycle t+1.

Counters:
- `free_count` updates one cycle after the allocation or issue edge.
- On a simultaneous allocation and issue, `free_count` is unchanged.

Full condition:
- With all entries busy, `alloc_ready`=0. It returns to 1 the cycle after an issue.

Reset or flush mid-operation:
- Pending entries are discarded. `issue_valid`=0 on the next cycle, including when a CDB broadcast arrives in the same cycle.

## Test plan

1. Reset, then allocate ADD 5+3 with both operands valid and tag 1, with `issue_ready`=1. Expect `issue_valid` the next cycle with opa=5, opb=3, rob_tag=1. Expect `free_count` 4→3→4.
2. Allocate tag 2 with opa waiting on tag 7 and opb=5. Broadcast cdb tag 7, data 10. Expect `issue_valid` one cycle after the broadcast with opa=10.
3. Hold `issue_ready`=0 and allocate 4 ready entries with tags 10–13. Expect `alloc_ready`=0, `free_count`=0, and a 5th `alloc_valid` ignored. Release `issue_ready`; expect issue order 10, 11, 12, 13.
4. Allocate tag 3 (waiting on 9), then tag 4 (ready). Expect tag 4 to issue first. Broadcast tag 9; expect tag 3 to issue next.
5. Allocate with opa tag 6 not valid while `cdb_valid` carries tag 6, data 0xFF in the same cycle. Expect `issue_valid` the next cycle with opa=0xFF.
6. With 3 entries busy, assert `flush` together with `alloc_valid`. Expect `free_count`=4 and `issue_valid`=0 the next cycle.

Source files
------------

// File: rtl/rs_array.sv
// rs_array: multi-entry reservation station in front of one functional unit.
// Entries capture operands from dispatch or from the CDB, and the oldest
// entry with both operands ready is offered to the FU. An age matrix keeps
// program order: age[i][j]=1 means entry i is older than entry j.
module rs_array #(
  parameter int NUM_ENTRIES = 4,
  parameter int XLEN        = 32,
  parameter int TAG_BITS    = 5,
  parameter int FUNC_BITS   = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic [XLEN-1:0]                  alloc_opa,
  input  logic [XLEN-1:0]                  alloc_opb,
  input  logic                             alloc_opa_valid,
  input  logic                             alloc_opb_valid,
  input  logic [TAG_BITS-1:0]              alloc_opa_tag,
  input  logic [TAG_BITS-1:0]              alloc_opb_tag,
  input  logic [TAG_BITS-1:0]              alloc_rob_tag,
  input  logic [FUNC_BITS-1:0]             alloc_func,
  input  logic [XLEN-1:0]                  alloc_npc,
  input  logic                             alloc_rd_mem,
  input  logic                             alloc_wr_mem,
  input  logic                             cdb_valid,
  input  logic [TAG_BITS-1:0]              cdb_tag,
  input  logic [XLEN-1:0]                  cdb_data,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [XLEN-1:0]                  issue_opa,
  output logic [XLEN-1:0]                  issue_opb,
  output logic [TAG_BITS-1:0]              issue_rob_tag,
  output logic [FUNC_BITS-1:0]             issue_func,
  output logic [XLEN-1:0]                  issue_npc,
  output logic                             issue_rd_mem,
  output logic                             issue_wr_mem,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] free_count
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int CW = $clog2(NUM_ENTRIES+1);

  // Control state (reset)
  logic [NUM_ENTRIES-1:0] busy;
  logic [NUM_ENTRIES-1:0] age [NUM_ENTRIES];
  logic                   lock_vld;
  logic [IW-1:0]          lock_idx;

  // Entry payload (no reset; qualified by busy)
  logic [XLEN-1:0]      opa     [NUM_ENTRIES];
  logic [XLEN-1:0]      opb     [NUM_ENTRIES];
  logic                 opa_v   [NUM_ENTRIES];
  logic                 opb_v   [NUM_ENTRIES];
  logic [TAG_BITS-1:0]  opa_tag [NUM_ENTRIES];
  logic [TAG_BITS-1:0]  opb_tag [NUM_ENTRIES];
  logic [TAG_BITS-1:0]  rob_tag [NUM_ENTRIES];
  logic [FUNC_BITS-1:0] func    [NUM_ENTRIES];
  logic [XLEN-1:0]      npc     [NUM_ENTRIES];
  logic                 rd_mem  [NUM_ENTRIES];
  logic                 wr_mem  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] ready;
  logic [NUM_ENTRIES-1:0] pick;
  logic                   sel_valid;
  logic [IW-1:0]          sel_idx;
  logic [IW-1:0]          alloc_idx;
  logic                   alloc_fire;
  logic                   issue_fire;
  logic [CW-1:0]          free_cnt;

  // Oldest-ready select from registered state; a stalled choice stays locked
  always_comb begin
    ready     = '0;
    pick      = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      ready[i] = busy[i] & opa_v[i] & opb_v[i];
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      pick[i] = ready[i];
      for (int j = 0; j < NUM_ENTRIES; j++)
        if (j != i && ready[j] && !age[i][j]) pick[i] = 1'b0;
    end
    if (lock_vld) begin
      sel_valid = 1'b1;
      sel_idx   = lock_idx;
    end else begin
      sel_valid = |pick;
      for (int i = NUM_ENTRIES-1; i >= 0; i--)
        if (pick[i]) sel_idx = IW'(i);
    end
  end

  // Lowest free slot and free-entry count from registered busy bits
  always_comb begin
    alloc_idx = '0;
    free_cnt  = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--)
      if (!busy[i]) alloc_idx = IW'(i);
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (!busy[i]) free_cnt = free_cnt + CW'(1);
  end

  assign alloc_ready = ~&busy;
  assign free_count  = free_cnt;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush & ~reset;
  assign issue_fire  = sel_valid & issue_ready;

  assign issue_valid   = sel_valid;
  assign issue_opa     = sel_valid ? opa[sel_idx]     : '0;
  assign issue_opb     = sel_valid ? opb[sel_idx]     : '0;
  assign issue_rob_tag = sel_valid ? rob_tag[sel_idx] : '0;
  assign issue_func    = sel_valid ? func[sel_idx]    : '0;
  assign issue_npc     = sel_valid ? npc[sel_idx]     : '0;
  assign issue_rd_mem  = sel_valid & rd_mem[sel_idx];
  assign issue_wr_mem  = sel_valid & wr_mem[sel_idx];

  // Busy bits, age matrix and issue lock
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= '0;
    end else if (flush) begin
      busy     <= '0;
      lock_vld <= 1'b0;
    end else begin
      if (issue_fire) busy[sel_idx] <= 1'b0;
      if (alloc_fire) begin
        busy[alloc_idx] <= 1'b1;
        // new entry is younger than everything currently held
        age[alloc_idx] <= '0;
        for (int j = 0; j < NUM_ENTRIES; j++)
          if (IW'(j) != alloc_idx) age[j][alloc_idx] <= 1'b1;
      end
      lock_vld <= sel_valid & ~issue_ready;
      lock_idx <= sel_idx;
    end
  end

  // Entry payload: allocation with CDB bypass, otherwise CDB wakeup
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc_fire && alloc_idx == IW'(i)) begin
        if (!alloc_opa_valid && cdb_valid && cdb_tag == alloc_opa_tag) begin
          opa[i]   <= cdb_data;
          opa_v[i] <= 1'b1;
        end else begin
          opa[i]   <= alloc_opa;
          opa_v[i] <= alloc_opa_valid;
        end
        if (!alloc_opb_valid && cdb_valid && cdb_tag == alloc_opb_tag) begin
          opb[i]   <= cdb_data;
          opb_v[i] <= 1'b1;
        end else begin
          opb[i]   <= alloc_opb;
          opb_v[i] <= alloc_opb_valid;
        end
        opa_tag[i] <= alloc_opa_tag;
        opb_tag[i] <= alloc_opb_tag;
        rob_tag[i] <= alloc_rob_tag;
        func[i]    <= alloc_func;
        npc[i]     <= alloc_npc;
        rd_mem[i]  <= alloc_rd_mem;
        wr_mem[i]  <= alloc_wr_mem;
      end else if (busy[i] && cdb_valid) begin
        if (!opa_v[i] && opa_tag[i] == cdb_tag) begin
          opa[i]   <= cdb_data;
          opa_v[i] <= 1'b1;
        end
        if (!opb_v[i] && opb_tag[i] == cdb_tag) begin
          opb[i]   <= cdb_data;
          opb_v[i] <= 1'b1;
        end
      end
    end
  end

endmodule
